// File: rtl/gate3_sweep_checker.sv
// Stimulus and checker for 3-input combinational gates. Walks {a,b,c} through all 8 vectors,
// samples y_in after a settle interval and scores it against EXPECT. Optional macro GATE_SWEEP_LOOP_EN.
module gate3_sweep_checker #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [7:0]  EXPECT        = 8'b1000_0000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       y_in,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] captured,
    output logic [3:0] mismatch_cnt,
    output logic [2:0] first_fail_idx,
    output logic       first_fail_valid
);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] abc_d;
    logic       busy_d, done_d, pass_d, ffv_d;
    logic [7:0] captured_d;
    logic [3:0] mismatch_d;
    logic [2:0] ffi_d;
    logic       miss;
    logic       clear_stats;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        abc_d       = {a, b, c};
        busy_d      = busy;
        done_d      = 1'b0;
        pass_d      = pass;
        captured_d  = captured;
        mismatch_d  = mismatch_cnt;
        ffi_d       = first_fail_idx;
        ffv_d       = first_fail_valid;
        miss        = (y_in != EXPECT[idx_q]);
        clear_stats = 1'b0;

        // Abort drops any sample taken in the same cycle; partial results stay visible.
        if (abort && (state_q == SETTLE || state_q == SAMPLE)) begin
            state_d = IDLE;
            idx_d   = 3'd0;
            cnt_d   = 4'd0;
            abc_d   = 3'b000;
            busy_d  = 1'b0;
            pass_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        clear_stats = 1'b1;
                        pass_d      = 1'b0;
                        busy_d      = 1'b1;
                        idx_d       = 3'd0;
                        cnt_d       = 4'd0;
                        abc_d       = 3'b000;
                        state_d     = SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        cnt_d   = 4'd0;
                        state_d = SAMPLE;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                SAMPLE: begin
                    captured_d[idx_q] = y_in;
                    if (miss) begin
                        mismatch_d = mismatch_cnt + 4'd1;
                        if (!first_fail_valid) begin
                            ffi_d = idx_q;
                            ffv_d = 1'b1;
                        end
                    end
                    if (idx_q == 3'd7) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        abc_d   = idx_q + 3'd1;
                        cnt_d   = 4'd0;
                        state_d = SETTLE;
                    end
                end
                DONE: begin
                    done_d = 1'b1;
                    pass_d = (mismatch_cnt == 4'd0);
                    abc_d  = 3'b000;
`ifdef GATE_SWEEP_LOOP_EN
                    clear_stats = 1'b1;
                    idx_d       = 3'd0;
                    cnt_d       = 4'd0;
                    state_d     = SETTLE;
`else
                    busy_d  = 1'b0;
                    state_d = IDLE;
`endif
                end
            endcase
        end

        if (clear_stats) begin
            captured_d = 8'h00;
            mismatch_d = 4'd0;
            ffi_d      = 3'd0;
            ffv_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            idx_q            <= 3'd0;
            cnt_q            <= 4'd0;
            {a, b, c}        <= 3'b000;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            captured         <= 8'h00;
            mismatch_cnt     <= 4'd0;
            first_fail_idx   <= 3'd0;
            first_fail_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register updates from the same pre-edge values.
            state_q          <= state_d;
            idx_q            <= idx_d;
            cnt_q            <= cnt_d;
            {a, b, c}        <= abc_d;
            busy             <= busy_d;
            done             <= done_d;
            pass             <= pass_d;
            captured         <= captured_d;
            mismatch_cnt     <= mismatch_d;
            first_fail_idx   <= ffi_d;
            first_fail_valid <= ffv_d;
        end
    end

endmodule

// File: tb/tb_gate3_sweep_checker.sv
// Scoreboard bench for gate3_sweep_checker: random gate truth tables, aborts, resets and restarts,
// each sweep scored against a truth-table model of the expected report.
`timescale 1ns/1ps
module tb_gate3_sweep_checker;

`ifdef GATE_SWEEP_LOOP_EN
    localparam int   S    = 1;
    localparam logic LOOP = 1'b1;
`else
    localparam int   S    = 2;
    localparam logic LOOP = 1'b0;
`endif
    localparam logic [7:0] EXP   = 8'h80;
    localparam int         SWEEP = 8 * (S + 1) + 1;

    typedef struct {
        int         due;
        logic [7:0] cap;
        logic [3:0] mm;
        logic       ffv;
        logic [2:0] ffi;
        logic       pass;
    } exp_t;

    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
    logic       y_in, a, b, c, busy, done, pass, first_fail_valid;
    logic [7:0] captured;
    logic [3:0] mismatch_cnt;
    logic [2:0] first_fail_idx;
    logic [7:0] gate_tt = EXP;

    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    assign y_in = gate_tt[{a, b, c}];

    gate3_sweep_checker #(.SETTLE_CYCLES(S), .EXPECT(EXP)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .y_in(y_in),
        .a(a), .b(b), .c(c), .busy(busy), .done(done), .pass(pass),
        .captured(captured), .mismatch_cnt(mismatch_cnt),
        .first_fail_idx(first_fail_idx), .first_fail_valid(first_fail_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Expected report after the first nvec vectors of a sweep against a gate with truth table tt.
    function automatic exp_t model(input logic [7:0] tt, input int nvec, input int due);
        exp_t       r;
        logic [7:0] mask, diff;
        mask   = 8'hFF >> (8 - nvec);
        diff   = (tt ^ EXP) & mask;
        r.due  = due;
        r.cap  = tt & mask;
        r.mm   = 4'($countones(diff));
        r.ffv  = |diff;
        r.ffi  = 3'd0;
        for (int i = 7; i >= 0; i--) if (diff[i]) r.ffi = 3'(i);
        r.pass = (nvec == 8) && (diff == 8'h00);
        return r;
    endfunction

    // Monitor: report fields come from the cycle before done, pass from the done cycle.
    logic [7:0] prev_cap;
    logic [3:0] prev_mm;
    logic       prev_ffv;
    logic [2:0] prev_ffi;
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                check("spurious_done", 32'(done), 32'd0);
            end else begin
                e = sb.pop_front();
                check("done_cycle", 32'(cyc), 32'(e.due));
                check("captured", 32'(prev_cap), 32'(e.cap));
                check("mismatch_cnt", 32'(prev_mm), 32'(e.mm));
                check("first_fail_valid", 32'(prev_ffv), 32'(e.ffv));
                if (e.ffv) check("first_fail_idx", 32'(prev_ffi), 32'(e.ffi));
                check("pass", 32'(pass), 32'(e.pass));
                check("busy_at_done", 32'(busy), 32'(LOOP));
            end
        end
        prev_cap = captured;
        prev_mm  = mismatch_cnt;
        prev_ffv = first_fail_valid;
        prev_ffi = first_fail_idx;
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_abc"}, 32'({a, b, c}), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_pass"}, 32'(pass), 32'd0);
        check({tag, "_captured"}, 32'(captured), 32'd0);
        check({tag, "_mismatch"}, 32'(mismatch_cnt), 32'd0);
        check({tag, "_ffi"}, 32'(first_fail_idx), 32'd0);
        check({tag, "_ffv"}, 32'(first_fail_valid), 32'd0);
    endtask

    // sc receives the edge count at the accepted start edge.
    task automatic pulse_start(input logic [7:0] tt, output int sc);
        @(negedge clk);
        gate_tt = tt;
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        sc = cyc;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 4 * SWEEP && sb.size() != 0; i++) @(negedge clk);
        check("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    task automatic run_sweep(input logic [7:0] tt, output exp_t e);
        int sc;
        pulse_start(tt, sc);
        e = model(tt, 8, sc + SWEEP);
        sb.push_back(e);
        wait_drain();
    endtask

    // Abort raised during cycle j after the start edge; only fully sampled vectors survive.
    task automatic abort_at(input logic [7:0] tt, input int j);
        int   sc;
        exp_t e;
        pulse_start(tt, sc);
        while (cyc - sc < j) @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        e = model(tt, j / (S + 1), 0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_abc", 32'({a, b, c}), 32'd0);
        check("abort_pass", 32'(pass), 32'd0);
        check("abort_captured", 32'(captured), 32'(e.cap));
        check("abort_mismatch", 32'(mismatch_cnt), 32'(e.mm));
        check("abort_ffv", 32'(first_fail_valid), 32'(e.ffv));
        if (e.ffv) check("abort_ffi", 32'(first_fail_idx), 32'(e.ffi));
    endtask

    task automatic reset_mid_sweep();
        int   sc;
        exp_t e;
        pulse_start(8'hFE, sc);
        e = model(8'hFE, 8, sc + SWEEP);
        sb.push_back(e);
        repeat (7) @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        sb.delete();
        #1 check_reset_vals("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   sc;
        int   lows;

        #12 check_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;

`ifdef GATE_SWEEP_LOOP_EN
        pulse_start(EXP, sc);
        for (int n = 1; n <= 3; n++) sb.push_back(model(EXP, 8, sc + n * SWEEP));
        lows = 0;
        for (int i = 0; i < 3 * SWEEP; i++) begin
            @(negedge clk);
            if (!busy) lows++;
            start = (i == 20);
        end
        start = 1'b0;
        wait_drain();
        check("loop_busy_held", 32'(lows), 32'd0);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        check("loop_abort_busy", 32'(busy), 32'd0);
        check("loop_abort_abc", 32'({a, b, c}), 32'd0);
        repeat (2 * SWEEP) @(negedge clk);
        check("loop_stays_idle", 32'(busy), 32'd0);
        abort_at(8'hFE, 4 * (S + 1));
        reset_mid_sweep();
        repeat (3) @(negedge clk);
`else
        // AND3 sweep: a,b,c step through the vectors every S+1 cycles.
        pulse_start(EXP, sc);
        sb.push_back(model(EXP, 8, sc + SWEEP));
        for (int k = 0; k < 8; k++) begin
            while (cyc - sc < k * (S + 1) + S) @(negedge clk);
            check("abc_step", 32'({a, b, c}), 32'(k));
            check("busy_sweep", 32'(busy), 32'd1);
        end
        wait_drain();
        check("idle_abc", 32'({a, b, c}), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);

        run_sweep(8'h00, e);
        run_sweep(8'hFE, e);
        repeat (3) @(negedge clk);
        check("hold_captured", 32'(captured), 32'(e.cap));
        check("hold_mismatch", 32'(mismatch_cnt), 32'(e.mm));
        check("hold_ffi", 32'(first_fail_idx), 32'(e.ffi));

        // Start re-pulsed mid-sweep must not disturb timing or results.
        pulse_start(8'($urandom), sc);
        sb.push_back(model(gate_tt, 8, sc + SWEEP));
        repeat (10) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_mid_start", 32'(busy), 32'd1);
        wait_drain();

        abort_at(8'hFE, 4 * (S + 1));
        run_sweep(EXP, e);

        // start and abort together in IDLE: abort wins.
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_busy", 32'(busy), 32'd0);
        repeat (SWEEP) @(negedge clk);
        check("start_abort_idle", 32'(busy), 32'd0);

        for (int i = 0; i < 8; i++) begin
            if ($urandom_range(1, 0) == 1) abort_at(8'($urandom), int'($urandom_range(8 * (S + 1) - 1, 0)));
            else run_sweep(8'($urandom), e);
        end

        reset_mid_sweep();
        run_sweep(8'h7F, e);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
